// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the iterative cipher.
// The S-box is computed as the multiplicative inverse followed by the affine map.
package aes_pkg;

  localparam int BLK = 128;

  function automatic int keyw(input int nk);
    return 128 * (nk + 7);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as b^254 (0 maps to 0), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] x;
    sq = b;
    x  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      x  = gf_mul(x, sq);
    end
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte k of a block lives at bits [8k:8k+7]; bytes are column-major.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:BLK-1] state,
  input  logic [0:BLK-1] round_key,
  input  logic           final_round,
  output logic [0:BLK-1] next_state
);

  logic [7:0] sb_s [16];
  logic [7:0] sr_s [16];
  logic [7:0] mc_s [16];

  // Round datapath; the last round bypasses MixColumns.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      sb_s[k] = sbox(state[8*k +: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_s[r + 4*c] = sb_s[r + 4*((c + r) & 3)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_s[4*c+0] = xtime(sr_s[4*c+0]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+1] = sr_s[4*c+0] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2]) ^ sr_s[4*c+2] ^ sr_s[4*c+3];
      mc_s[4*c+2] = sr_s[4*c+0] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2]) ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
      mc_s[4*c+3] = xtime(sr_s[4*c+0]) ^ sr_s[4*c+0] ^ sr_s[4*c+1] ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
    end
    next_state = {BLK{1'b0}};
    for (int k = 0; k < 16; k++) begin
      next_state[8*k +: 8] = (final_round ? sr_s[k] : mc_s[k]) ^ round_key[8*k +: 8];
    end
  end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES encryptor, one round per enabled clock; the running state is
// exposed on out so each round can be observed.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [0:BLK-1]        plainText,
  input  logic [0:keyw(Nk)-1]   keysContainer,
  output logic [0:BLK-1]        out,
  output logic                  done
);

  localparam int Nr = Nk + 6;
  localparam int RW = $clog2(Nr + 2);
  localparam logic [RW-1:0] RND_LAST = RW'(Nr);
  localparam logic [RW-1:0] RND_DONE = RW'(Nr + 1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_iter_cipher: Nk must be 4, 6 or 8");
  end

  logic [0:BLK-1] out_q, out_d;
  logic [RW-1:0]  rnd_q, rnd_d;
  logic           done_q, done_d;
  logic [RW-1:0]  key_idx_s;
  logic [0:BLK-1] key_s;
  logic [0:BLK-1] round_s;

  // Key slice for the current round; clamped once the run has finished.
  always_comb begin
    if (rnd_q > RND_LAST) begin
      key_idx_s = RND_LAST;
    end else begin
      key_idx_s = rnd_q;
    end
    key_s = keysContainer[BLK*int'(key_idx_s) +: BLK];
  end

  aes_round u_round (
    .state       (out_q),
    .round_key   (key_s),
    .final_round (rnd_q == RND_LAST),
    .next_state  (round_s)
  );

  // Round sequencing: initial AddRoundKey, middle rounds, final round, then hold.
  always_comb begin
    out_d  = out_q;
    rnd_d  = rnd_q;
    done_d = done_q;
    if (!enable) begin
      rnd_d  = {RW{1'b0}};
      done_d = 1'b0;
    end else if (rnd_q == {RW{1'b0}}) begin
      out_d = plainText ^ key_s;
      rnd_d = RW'(1);
    end else if (rnd_q < RND_LAST) begin
      out_d = round_s;
      rnd_d = rnd_q + RW'(1);
    end else if (rnd_q == RND_LAST) begin
      out_d  = round_s;
      rnd_d  = RND_DONE;
      done_d = 1'b1;
    end else begin
      rnd_d = RND_DONE;
    end
  end

  // State, round counter and completion flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= {BLK{1'b0}};
      rnd_q  <= {RW{1'b0}};
      done_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      rnd_q  <= rnd_d;
      done_q <= done_d;
    end
  end

  assign out  = out_q;
  assign done = done_q;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Scoreboard bench for aes_iter_cipher: three instances (Nk=4/6/8) run side by side
// against a byte-level reference model plus the FIPS-197 known answers.
module tb_aes_iter_cipher;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [0:127]        pt;
  logic [0:128*11-1]   kc4;
  logic [0:128*13-1]   kc6;
  logic [0:128*15-1]   kc8;
  logic [0:127]        out4, out6, out8;
  logic                done4, done6, done8;

  always #5 clk = ~clk;

  aes_iter_cipher #(.Nk(4)) u_dut4 (.clk(clk), .reset(reset), .enable(enable),
    .plainText(pt), .keysContainer(kc4), .out(out4), .done(done4));
  aes_iter_cipher #(.Nk(6)) u_dut6 (.clk(clk), .reset(reset), .enable(enable),
    .plainText(pt), .keysContainer(kc6), .out(out6), .done(done6));
  aes_iter_cipher #(.Nk(8)) u_dut8 (.clk(clk), .reset(reset), .enable(enable),
    .plainText(pt), .keysContainer(kc8), .out(out8), .done(done8));

  int checks = 0;
  int errors = 0;

  logic [7:0]   sb_t [256];
  logic [127:0] rk [3][15];
  int           nr_t [3] = '{10, 12, 14};
  logic [127:0] m_out [3];
  int           m_rnd [3];
  logic         m_done [3];

  typedef struct {
    int           sel;
    string        tag;
    logic [127:0] v;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] t_xt(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = t_xt(t);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (t_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = 8'h63;
      for (int i = 0; i < 5; i++) s = s ^ ((inv << i) | (inv >> (8 - i)));
      sb_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb_t[w[31:24]], sb_t[w[23:16]], sb_t[w[15:8]], sb_t[w[7:0]]};
  endfunction

  task automatic expand(input int idx, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) begin
        w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = t_xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r < nk + 7; r++) rk[idx][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] m_round(input logic [127:0] s, input logic [127:0] k, input bit fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] m [16];
    logic [7:0] coef [4];
    logic [127:0] r;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) b[i] = sb_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) t[row + 4*c] = b[row + 4*((c + row) % 4)];
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        m[row + 4*c] = 8'h00;
        for (int j = 0; j < 4; j++)
          m[row + 4*c] = m[row + 4*c] ^ t_mul(coef[(j - row + 4) % 4], t[j + 4*c]);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (fin ? t[i] : m[i]) ^ k[127-8*i -: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_out[d] = 128'h0; m_rnd[d] = 0; m_done[d] = 1'b0;
    end
  endtask

  task automatic model_step(input bit en);
    for (int d = 0; d < 3; d++) begin
      if (!en) begin
        m_rnd[d] = 0; m_done[d] = 1'b0;
      end else if (m_rnd[d] == 0) begin
        m_out[d] = pt ^ rk[d][0]; m_rnd[d] = 1;
      end else if (m_rnd[d] <= nr_t[d]) begin
        m_out[d] = m_round(m_out[d], rk[d][m_rnd[d]], m_rnd[d] == nr_t[d]);
        if (m_rnd[d] == nr_t[d]) m_done[d] = 1'b1;
        m_rnd[d]++;
      end
    end
  endtask

  function automatic logic [127:0] observe(input int sel);
    case (sel)
      0: return out4;
      1: return out6;
      2: return out8;
      3: return {127'h0, done4};
      4: return {127'h0, done6};
      5: return {127'h0, done8};
      default: return 128'h0;
    endcase
  endfunction

  // Drive one clock with the given enable; expectations go through the scoreboard.
  task automatic step(input bit en, input string ph);
    exp_t e;
    enable = en;
    model_step(en);
    for (int d = 0; d < 3; d++) begin
      e.sel = d;     e.tag = $sformatf("%s_out_nk%0d", ph, 4 + 2*d);  e.v = m_out[d];
      sb_q.push_back(e);
      e.sel = d + 3; e.tag = $sformatf("%s_done_nk%0d", ph, 4 + 2*d); e.v = {127'h0, m_done[d]};
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.v);
    end
  endtask

  localparam logic [127:0] R1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] R2  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pt     = 128'h00112233445566778899aabbccddeeff;
    build_sbox();
    expand(0, 4); expand(1, 6); expand(2, 8);
    for (int r = 0; r < 11; r++) kc4[128*r +: 128] = rk[0][r];
    for (int r = 0; r < 13; r++) kc6[128*r +: 128] = rk[1][r];
    for (int r = 0; r < 15; r++) kc8[128*r +: 128] = rk[2][r];
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out4", out4, 128'h0);
    check("rst_out8", out8, 128'h0);
    check("rst_done4", {127'h0, done4}, 128'h0);
    reset = 1'b1;

    // Full run: all three key sizes, then hold after completion.
    for (int e = 1; e <= 20; e++) begin
      step(1'b1, "run");
      if (e == 1)  check("kat4_r1", out4, R1);
      if (e == 2)  check("kat4_r2", out4, R2);
      if (e == 11) begin
        check("kat4_ct", out4, CT4);
        check("kat4_done", {127'h0, done4}, 128'h1);
      end
      if (e == 12) check("nk6_done_early", {127'h0, done6}, 128'h0);
      if (e == 13) begin
        check("kat6_ct", out6, CT6);
        check("kat6_done", {127'h0, done6}, 128'h1);
      end
      if (e == 15) check("kat8_ct", out8, CT8);
      if (e == 16) begin
        check("hold4_ct", out4, CT4);
        check("hold4_done", {127'h0, done4}, 128'h1);
      end
    end

    // Asynchronous abort mid-run.
    step(1'b0, "abort");
    for (int e = 0; e < 5; e++) step(1'b1, "abort");
    #2 reset = 1'b0;
    #1;
    check("async_out4", out4, 128'h0);
    check("async_out6", out6, 128'h0);
    check("async_done4", {127'h0, done4}, 128'h0);
    model_reset();
    @(posedge clk); #1;
    check("inrst_out4", out4, 128'h0);
    reset = 1'b1;
    for (int e = 1; e <= 11; e++) step(1'b1, "rerun");
    check("rerun_ct4", out4, CT4);
    check("rerun_done4", {127'h0, done4}, 128'h1);

    // Enable dropped after round 3, then a restart from plaintext.
    step(1'b0, "pause");
    for (int e = 0; e < 4; e++) step(1'b1, "pause");
    for (int e = 0; e < 3; e++) step(1'b0, "frozen");
    step(1'b1, "resume");
    check("resume_r1", out4, R1);
    for (int e = 2; e <= 11; e++) step(1'b1, "resume");
    check("resume_ct4", out4, CT4);
    check("resume_done4", {127'h0, done4}, 128'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iter_cipher.md
Name: aes_iter_cipher

Overview:
- Iterative AES forward cipher (FIPS-197) that computes one round per clock.
- Takes a 128-bit plaintext and a pre-expanded round-key container from the key-expansion block.
- Exposes the running state after every round, so the top level can display and check each round on the 7-segment path.
- Key size is selected by parameter (AES-128/192/256).

Parameters:
- Nk, 4, key length in 32-bit words (4, 6 or 8).
- Nr, Nk+6, number of rounds (10, 12 or 14); derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run/hold; low parks the round counter at 0.
- plainText  input  [0:127]  input block; bit 0 is the MSB of byte 0.
- keysContainer  input  [0:128*(Nr+1)-1]  round keys; key i is at bits [128*i : 128*i+127], key 0 first.
- out  output  [0:127]  current state, byte order as plainText.
- done  output  1  high once the final round has been written to out.

Behaviour:
- State layout:
  - Byte k is out[8k:8k+7].
  - Column-major: bytes 0..3 form column 0.
- Round counter rnd:
  - Range 0..Nr+1, width ceil(log2(Nr+2)).
  - Saturates at Nr+1; it never wraps.
- reset low (async), any time including mid-operation:
  - out=0, rnd=0, done=0.
  - The operation is aborted immediately.
- enable low (not in reset):
  - rnd<=0 and done<=0.
  - out holds its value.
- enable high, on each clock edge:
  - rnd==0: out<=plainText XOR key0; rnd<=1.
  - 1<=rnd<=Nr-1: out<=AddRoundKey(MixColumns(ShiftRows(SubBytes(out))), key[rnd]); rnd<=rnd+1.
  - rnd==Nr: out<=AddRoundKey(ShiftRows(SubBytes(out)), key[Nr]); rnd<=Nr+1; done<=1.
  - rnd==Nr+1: out and done hold.
- Latency:
  - Ciphertext appears on out after Nr+1 enabled edges: 11 for Nk=4, 13 for Nk=6, 15 for Nk=8.
  - Intermediate round states are visible one edge apart.
- Restart: deasserting then reasserting enable restarts from plainText.
- plainText and keysContainer must be stable while enabled; they are sampled every round, not latched.
- SubBytes uses the standard AES S-box, implemented as combinational logic.
- ShiftRows: row r is rotated left by r bytes.
- MixColumns:
  - Fixed matrix {02,03,01,01} applied over GF(2^8).
  - Reduction polynomial 0x11B; xtime is implemented as a shift plus conditional XOR of 0x1B.
- Nk values other than 4, 6 or 8 are unsupported; the design raises an elaboration-time error.

Decomposition:
- Package aes_pkg:
  - S-box function sbox(byte).
  - xtime function.
  - Constants BLK=128 and KEYW(Nk)=128*(Nk+7).
- Sub-module aes_round (combinational): inputs state, roundKey and final flag (final skips MixColumns); output next state.
- aes_iter_cipher contains:
  - The counter and state register.
  - The initial AddRoundKey.
  - The key slice mux.

Test Plan:
- Nk=4, pt 00112233445566778899aabbccddeeff, key 000102..0f expanded, reset released, enable high:
  - After edge 1, out=00102030405060708090a0b0c0d0e0f0.
  - After edge 2, out=89d810e8855ace682d1843d8cb128fe4.
  - After edge 11, out=69c4e0d86a7b0430d8cdb78070b4c55a and done=1.
- Nk=6, same pt, key 000102..17 expanded -> after edge 13, out=dda97ca4864cdfe06eaf70a0ec0d7191 and done=1; done=0 before edge 13.
- Nk=8, same pt, key 000102..1f expanded -> after edge 15, out=8ea2b7ca516745bfeafc49904b496089.
- Nk=4, after done, keep enable high for 5 more edges -> out stays 69c4e0d8..., done stays 1.
- Nk=4, assert reset low asynchronously at round 5 (between edges) -> out=0 and done=0 immediately; after release, 11 enabled edges give 69c4e0d8... again.
- Nk=4, drop enable at round 4 for 3 edges -> out frozen at the round-3 state; on re-enable, edge 1 gives 00102030...f0 and the run completes normally.
